// File: rtl/phy_pkg.sv
// phy_pkg: shared PHY constants and the rx lane state encoding.
package phy_pkg;

    localparam logic [7:0] COM_SYM_DEFAULT    = 8'hBC;
    localparam int         LOCK_COUNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/phy_rx_aligner.sv
// phy_rx_aligner: comma-based byte alignment and lock state machine for one rx lane.
module phy_rx_aligner
    import phy_pkg::*;
#(
    parameter int              DATA_W     = 8,
    parameter logic [DATA_W-1:0] COM_SYM  = COM_SYM_DEFAULT,
    parameter int              LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
    input  logic              clk_8f,
    input  logic              reset_L,
    input  logic              serial_in,
    output logic [DATA_W-1:0] cand,
    output logic              boundary,
    output rx_state_t         state
);

    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] sr;
    logic [CW-1:0]     bit_cnt, bit_cnt_nx;
    logic [3:0]        com_cnt, com_cnt_nx;
    rx_state_t         state_nx;
    logic              is_com;

    assign cand   = {sr[DATA_W-2:0], serial_in};
    assign is_com = cand == COM_SYM;

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            sr      <= '0;
            state   <= HUNT;
            bit_cnt <= '0;
            com_cnt <= '0;
        end else begin
            sr      <= cand;
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            com_cnt <= com_cnt_nx;
        end
    end

    // bit_cnt only runs once aligned; any drop back to HUNT restarts it at 0
    always_comb begin
        state_nx   = state;
        com_cnt_nx = com_cnt;
        bit_cnt_nx = (state == HUNT) ? '0 : bit_cnt + 1'b1;
        case (state)
            HUNT: if (is_com) begin
                state_nx   = (LOCK_COUNT == 1) ? ACTIVE : SYNC;
                com_cnt_nx = 4'd1;
            end
            SYNC: if (boundary) begin
                if (is_com) begin
                    com_cnt_nx = com_cnt + 4'd1;
                    state_nx   = (com_cnt_nx == LOCK_COUNT[3:0]) ? ACTIVE : SYNC;
                end else begin
                    state_nx   = HUNT;
                    com_cnt_nx = '0;
                    bit_cnt_nx = '0;
                end
            end
            ACTIVE: ;
            default: state_nx = HUNT;
        endcase
    end

    always_comb begin
        boundary = (state != HUNT) && (bit_cnt == '1);
    end

endmodule

// File: rtl/phy_rx_lane.sv
// phy_rx_lane: single-lane serial-to-parallel receiver with comma lock.
// Optional rx_count statistics port enabled by PHY_RX_LANE_STATS_EN.
module phy_rx_lane
    import phy_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] COM_SYM    = COM_SYM_DEFAULT,
    parameter int                LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
    input  logic              clk_8f,
    input  logic              reset_L,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              active,
    output logic              byte_strobe
`ifdef PHY_RX_LANE_STATS_EN
    ,
    output logic [15:0]       rx_count
`endif
);

    logic [DATA_W-1:0] cand;
    logic              boundary;
    rx_state_t         state;
    logic              act_bnd;
    logic              hit;

    phy_rx_aligner #(
        .DATA_W     (DATA_W),
        .COM_SYM    (COM_SYM),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_aligner (
        .clk_8f    (clk_8f),
        .reset_L   (reset_L),
        .serial_in (serial_in),
        .cand      (cand),
        .boundary  (boundary),
        .state     (state)
    );

    assign act_bnd = (state == ACTIVE) && boundary;
    assign hit     = act_bnd && (cand != COM_SYM);

    // a comma in ACTIVE is idle: valid drops but the last data byte is kept
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            data_out    <= '0;
            valid_out   <= 1'b0;
            active      <= 1'b0;
            byte_strobe <= 1'b0;
        end else begin
            byte_strobe <= boundary;
            active      <= state == ACTIVE;
            if (act_bnd) valid_out <= hit;
            if (hit) data_out <= cand;
        end
    end

`ifdef PHY_RX_LANE_STATS_EN
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) rx_count <= '0;
        else if (hit && rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
    end
`endif

endmodule

// File: doc/phy_rx_lane.md
Name: phy_rx_lane

Overview:
- Single-lane serial-to-parallel receiver for the PHY serial link.
- Consumes the 1-bit line driven by the transmit lane (one bit per clk_8f cycle, MSB first).
- Finds byte alignment using the idle/comma symbol 8'hBC, locks after a run of consecutive commas, then delivers data bytes with a valid flag.
- The PHY receive path instantiates one per lane (transfer_0, transfer_1).

Parameters:
- DATA_W, 8, symbol width in bits.
- COM_SYM, 8'hBC, comma/idle symbol sent by the transmitter when it has no valid data.
- LOCK_COUNT, 4, consecutive aligned commas required to enter ACTIVE (legal range 1..15).

Ports:
- clk_8f  input  1  bit clock; all logic on its rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- serial_in  input  1  serial line from the transmit lane, MSB first.
- data_out  output  DATA_W  last received data byte.
- valid_out  output  1  data_out holds a data (non-comma) byte for the current byte period.
- active  output  1  lane is locked (state ACTIVE).
- byte_strobe  output  1  one-cycle pulse at each aligned byte boundary (SYNC/ACTIVE only).

Behaviour:
- Reset values while reset_L=0: data_out=0, valid_out=0, active=0, byte_strobe=0, state=HUNT, bit_cnt=0, com_cnt=0, shift register=0.
- Reset is asynchronous; asserting it mid-byte discards the partial byte and any lock.
- Shift register: sr <= {sr[DATA_W-2:0], serial_in} every cycle.
- Candidate byte: cand = {sr[DATA_W-2:0], serial_in}, the current bit plus the previous 7.
- bit_cnt (3 bits) increments and wraps 7->0 in SYNC and ACTIVE. A byte boundary is a cycle with bit_cnt==7.
- HUNT:
  - Evaluate cand every cycle.
  - If cand==COM_SYM: go to SYNC, set bit_cnt=0 (the next bit is bit 7 of a new byte) and com_cnt=1.
  - If LOCK_COUNT==1, go directly to ACTIVE instead.
- SYNC, at each byte boundary:
  - cand==COM_SYM: increment com_cnt. If com_cnt+1==LOCK_COUNT, go to ACTIVE.
  - Otherwise: go to HUNT, com_cnt=0, bit_cnt=0.
- ACTIVE, at each byte boundary:
  - cand!=COM_SYM: data_out<=cand, valid_out<=1.
  - cand==COM_SYM: valid_out<=0, data_out holds its value.
  - valid_out and data_out are stable for the full 8-cycle byte period.
  - ACTIVE has no exit except reset.
- Latency: data_out/valid_out update on the same edge that samples the last bit (LSB) of the byte, so they are visible 1 cycle after the LSB is on the line.
- byte_strobe=1 for exactly the cycle after each boundary edge in SYNC/ACTIVE; 0 in HUNT.
- active is a registered decode of state==ACTIVE.
- A data byte equal to COM_SYM is always treated as idle. This is a protocol property, not an error.

Optional Feature:
- Macro: PHY_RX_LANE_STATS_EN.
- When defined, add output rx_count (16 bits, reset 0). It increments at every ACTIVE boundary with a non-comma byte and saturates at 16'hFFFF.
- When undefined, the port and the counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package phy_pkg holds:
  - COM_SYM_DEFAULT=8'hBC;
  - the rx lane state encoding (HUNT=2'd0, SYNC=2'd1, ACTIVE=2'd2);
  - LOCK_COUNT_DEFAULT=4.
- One natural sub-module, phy_rx_aligner: shift register, bit_cnt, com_cnt and state machine, exporting cand, boundary and state. The top adds the output registers and the optional stats.

Test Plan:
- Reset mid-byte: drive 3 commas plus 4 bits, pulse reset_L low -> all outputs 0, state HUNT; lock requires 4 fresh commas afterwards.
- Lock-up at a random bit offset: send 3 junk bits, then 4x 8'hBC -> active=1 one cycle after the 4th comma's LSB edge; no valid_out before that.
- Data delivery: after lock, send 8'h5A, 8'hBC, 8'hC3 -> valid_out=1/data 5A for 8 cycles, then valid_out=0 with data_out still 5A, then valid_out=1/C3; each update 1 cycle after the LSB.
- Broken sync: send BC, BC, 8'h11 -> returns to HUNT, active stays 0; following 4x BC locks.
- Stats (PHY_RX_LANE_STATS_EN): after lock, send 10 data bytes interleaved with 5 commas -> rx_count==10. Force rx_count to 16'hFFFF, send 1 data byte -> rx_count stays 16'hFFFF.
